// File: rtl/map_mem_seq_pkg.sv
// Shared types for the mapper memory sequencer: the MemCtrl request bundle,
// the sequencer FSM state and the queued request record.
package map_mem_seq_pkg;

  localparam int MSEQ_ADDR_W = 23;

  localparam logic MSEQ_DIR_RD = 1'b0;
  localparam logic MSEQ_DIR_WR = 1'b1;

  typedef struct packed {
    logic                   ce;
    logic                   oe;
    logic                   we;
    logic [MSEQ_ADDR_W-1:0] addr;
    logic [7:0]             dati;
  } mem_ctrl_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACT,
    HOLD
  } mseq_state_t;

  typedef struct packed {
    logic                   dir;
    logic [MSEQ_ADDR_W-1:0] addr;
    logic [7:0]             dat;
  } mseq_req_t;

endpackage

// File: rtl/mseq_req_det.sv
// Turns level-style MemCtrl strobes into single access requests and keeps a
// one-entry pending slot for requests that arrive while the sequencer is busy.
module mseq_req_det
  import map_mem_seq_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  mem_ctrl_t ctrl,
  input  logic      idle,
  output mseq_req_t req,
  output logic      req_vld,
  output logic      pend_vld
);

  logic                   rd_now, wr_now, rd_det, wr_det, det;
  mseq_req_t              det_req;
  logic                   rd_prev_q, rd_prev_d, wr_prev_q, wr_prev_d;
  logic [MSEQ_ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic                   pend_vld_q, pend_vld_d;
  mseq_req_t              pend_q, pend_d;

  always_comb begin
    rd_now       = ctrl.ce & ctrl.oe & ~ctrl.we;
    wr_now       = ctrl.ce & ctrl.we;
    rd_det       = rd_now & (~rd_prev_q | (ctrl.addr != rd_addr_q));
    wr_det       = wr_now & (~wr_prev_q | (ctrl.addr != wr_addr_q));
    det          = rd_det | wr_det;
    det_req.dir  = wr_det ? MSEQ_DIR_WR : MSEQ_DIR_RD;
    det_req.addr = ctrl.addr;
    det_req.dat  = ctrl.dati;

    rd_prev_d = rd_now;
    wr_prev_d = wr_now;
    rd_addr_d = rd_det ? ctrl.addr : rd_addr_q;
    wr_addr_d = wr_det ? ctrl.addr : wr_addr_q;

    // The pending entry always wins the idle slot; a fresh request then refills it.
    req_vld = pend_vld_q | det;
    req     = pend_vld_q ? pend_q : det_req;

    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
    if (idle) begin
      if (pend_vld_q) begin
        pend_vld_d = det;
        pend_d     = det_req;
      end
    end else if (det) begin
      if (!(pend_vld_q && (pend_q.dir == MSEQ_DIR_WR) && !wr_det)) begin
        pend_vld_d = 1'b1;
        pend_d     = det_req;
      end
    end
  end

  assign pend_vld = pend_vld_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_prev_q  <= 1'b0;
      wr_prev_q  <= 1'b0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
    end else begin
      rd_prev_q  <= rd_prev_d;
      wr_prev_q  <= wr_prev_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
    end
  end

endmodule

// File: rtl/map_mem_seq.sv
// Sequences one mapper MemCtrl channel into timed SRAM/PSRAM strobes
// (SETUP, wait-stated ACT, HOLD) and returns read data on mem_do.
module map_mem_seq
  import map_mem_seq_pkg::*;
#(
  parameter int ADDR_W   = 23,
  parameter int RD_WS    = 3,
  parameter int WR_WS    = 3,
  parameter int HOLD_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_ce,
  input  logic              req_oe,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_dati,
  output logic [7:0]        mem_do,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_dq_o,
  output logic              mem_dq_oe,
  input  logic [7:0]        mem_dq_i,
  output logic              mem_ce_n,
  output logic              mem_oe_n,
  output logic              mem_we_n
);

  localparam logic [3:0] RD_LOAD   = 4'(RD_WS - 1);
  localparam logic [3:0] WR_LOAD   = 4'(WR_WS - 1);
  localparam logic [3:0] HOLD_LOAD = 4'((HOLD_CYC > 0) ? (HOLD_CYC - 1) : 0);

  mem_ctrl_t   ctrl;
  mseq_req_t   req;
  logic        req_vld, pend_vld, idle;

  mseq_state_t       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              dir_q, dir_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        dq_o_q, dq_o_d;
  logic [7:0]        do_q, do_d;
  logic              dq_oe_q, dq_oe_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;

  assign ctrl.ce   = req_ce;
  assign ctrl.oe   = req_oe;
  assign ctrl.we   = req_we;
  assign ctrl.addr = MSEQ_ADDR_W'(req_addr);
  assign ctrl.dati = req_dati;
  assign idle      = (state_q == IDLE);

  mseq_req_det u_req_det (
    .clk      (clk),
    .rst_n    (rst_n),
    .ctrl     (ctrl),
    .idle     (idle),
    .req      (req),
    .req_vld  (req_vld),
    .pend_vld (pend_vld)
  );

  // Strobe values are computed for the state being entered, so every output is a flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    addr_d  = addr_q;
    dq_o_d  = dq_o_q;
    do_d    = do_q;
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    dq_oe_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_vld) begin
          state_d = SETUP;
          dir_d   = req.dir;
          addr_d  = ADDR_W'(req.addr);
          dq_o_d  = req.dat;
          ce_n_d  = 1'b0;
          dq_oe_d = (req.dir == MSEQ_DIR_WR);
        end
      end
      SETUP: begin
        state_d = ACT;
        ce_n_d  = 1'b0;
        oe_n_d  = (dir_q == MSEQ_DIR_WR);
        we_n_d  = (dir_q == MSEQ_DIR_RD);
        dq_oe_d = (dir_q == MSEQ_DIR_WR);
        cnt_d   = (dir_q == MSEQ_DIR_WR) ? WR_LOAD : RD_LOAD;
      end
      ACT: begin
        if (cnt_q != 4'd0) begin
          cnt_d   = cnt_q - 4'd1;
          ce_n_d  = 1'b0;
          oe_n_d  = oe_n_q;
          we_n_d  = we_n_q;
          dq_oe_d = dq_oe_q;
        end else begin
          if (dir_q == MSEQ_DIR_RD) do_d = mem_dq_i;
          if (HOLD_CYC == 0) begin
            state_d = IDLE;
          end else begin
            state_d = HOLD;
            cnt_d   = HOLD_LOAD;
            dq_oe_d = (dir_q == MSEQ_DIR_WR);
          end
        end
      end
      HOLD: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else               state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      dir_q   <= MSEQ_DIR_RD;
      addr_q  <= '0;
      dq_o_q  <= 8'h00;
      do_q    <= 8'hFF;
      dq_oe_q <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      addr_q  <= addr_d;
      dq_o_q  <= dq_o_d;
      do_q    <= do_d;
      dq_oe_q <= dq_oe_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
    end
  end

  assign mem_do    = do_q;
  assign mem_addr  = addr_q;
  assign mem_dq_o  = dq_o_q;
  assign mem_dq_oe = dq_oe_q;
  assign mem_ce_n  = ce_n_q;
  assign mem_oe_n  = oe_n_q;
  assign mem_we_n  = we_n_q;
  assign busy      = (state_q != IDLE) | pend_vld;

endmodule

// File: tb/tb_map_mem_seq.sv
// Bench for map_mem_seq: directed scenarios plus a randomized run against a
// transaction-schedule reference model.
module tb_map_mem_seq;

  localparam int AW       = 23;
  localparam int RD_WS    = 3;
  localparam int WR_WS    = 3;
  localparam int HOLD_CYC = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_ce, req_oe, req_we;
  logic [AW-1:0] req_addr;
  logic [7:0]    req_dati;
  logic [7:0]    mem_do;
  logic          busy;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_dq_o;
  logic          mem_dq_oe;
  logic [7:0]    mem_dq_i;
  logic          mem_ce_n, mem_oe_n, mem_we_n;
  logic [7:0]    dq_noise;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] addr_tab [4] = '{23'h000010, 23'h000011, 23'h006001, 23'h7FFFFF};

  always #5 clk = ~clk;

  map_mem_seq #(
    .ADDR_W   (AW),
    .RD_WS    (RD_WS),
    .WR_WS    (WR_WS),
    .HOLD_CYC (HOLD_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_ce    (req_ce),
    .req_oe    (req_oe),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_dati  (req_dati),
    .mem_do    (mem_do),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_dq_o  (mem_dq_o),
    .mem_dq_oe (mem_dq_oe),
    .mem_dq_i  (mem_dq_i),
    .mem_ce_n  (mem_ce_n),
    .mem_oe_n  (mem_oe_n),
    .mem_we_n  (mem_we_n)
  );

  function automatic logic [7:0] data_of(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  // External memory: contents are a fixed function of the address, optionally perturbed.
  always_comb mem_dq_i = data_of(mem_addr) ^ dq_noise;

  task automatic idle_inputs();
    req_ce = 1'b0;
    req_oe = 1'b0;
    req_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    total++; if (mem_ce_n !== 1'b1) begin bad++; $display("FAIL rst_ce_n got=%b want=1", mem_ce_n); end
    total++; if (mem_oe_n !== 1'b1) begin bad++; $display("FAIL rst_oe_n got=%b want=1", mem_oe_n); end
    total++; if (mem_we_n !== 1'b1) begin bad++; $display("FAIL rst_we_n got=%b want=1", mem_we_n); end
    total++; if (mem_dq_oe !== 1'b0) begin bad++; $display("FAIL rst_dq_oe got=%b want=0", mem_dq_oe); end
    total++; if (mem_addr !== '0) begin bad++; $display("FAIL rst_addr got=%h want=0", mem_addr); end
    total++; if (mem_dq_o !== 8'h00) begin bad++; $display("FAIL rst_dq_o got=%h want=00", mem_dq_o); end
    total++; if (mem_do !== 8'hFF) begin bad++; $display("FAIL rst_do got=%h want=ff", mem_do); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read();
    int ce_cnt = 0, oe_cnt = 0, do_edge = -1;
    logic busy3 = 1'b0, busy6 = 1'b1;
    dq_noise = 8'h5A ^ data_of(23'h000123);
    req_ce = 1'b1; req_oe = 1'b1; req_we = 1'b0; req_addr = 23'h000123;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      if (!mem_ce_n) ce_cnt++;
      if (!mem_oe_n) oe_cnt++;
      if (do_edge < 0 && mem_do == 8'h5A) do_edge = e;
      if (e == 3) busy3 = busy;
      if (e == 6) busy6 = busy;
    end
    idle_inputs();
    total++; if (ce_cnt != 4) begin bad++; $display("FAIL rd_ce_cycles got=%0d want=4", ce_cnt); end
    total++; if (oe_cnt != 3) begin bad++; $display("FAIL rd_oe_cycles got=%0d want=3", oe_cnt); end
    total++; if (do_edge != 5) begin bad++; $display("FAIL rd_latency got=%0d want=5", do_edge); end
    total++; if (busy3 !== 1'b1) begin bad++; $display("FAIL rd_busy_mid got=%b want=1", busy3); end
    total++; if (busy6 !== 1'b0) begin bad++; $display("FAIL rd_busy_after got=%b want=0", busy6); end
    total++; if (mem_addr !== 23'h000123) begin bad++; $display("FAIL rd_addr got=%h want=000123", mem_addr); end
    @(negedge clk);
    dq_noise = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_write();
    int we_low = 0, we_fall = 0, dqoe_cnt = 0, dqoe_first = -1, dqoe_last = -1;
    logic prev_we_n = 1'b1, dq_bad = 1'b0;
    req_ce = 1'b1; req_oe = 1'b0; req_we = 1'b1; req_addr = 23'h006001; req_dati = 8'hC3;
    for (int e = 1; e <= 14; e++) begin
      @(negedge clk);
      if (!mem_we_n) begin
        we_low++;
        if (mem_dq_o !== 8'hC3 || mem_dq_oe !== 1'b1) dq_bad = 1'b1;
      end
      if (prev_we_n && !mem_we_n) we_fall++;
      prev_we_n = mem_we_n;
      if (mem_dq_oe) begin
        dqoe_cnt++;
        if (dqoe_first < 0) dqoe_first = e;
        dqoe_last = e;
      end
      if (e == 10) idle_inputs();
    end
    total++; if (we_low != 3) begin bad++; $display("FAIL wr_we_cycles got=%0d want=3", we_low); end
    total++; if (we_fall != 1) begin bad++; $display("FAIL wr_pulses got=%0d want=1", we_fall); end
    total++; if (dq_bad) begin bad++; $display("FAIL wr_dq_during_we got=%h want=c3", mem_dq_o); end
    total++; if (dqoe_first != 1) begin bad++; $display("FAIL wr_dqoe_first got=%0d want=1", dqoe_first); end
    total++; if (dqoe_last != 5) begin bad++; $display("FAIL wr_dqoe_last got=%0d want=5", dqoe_last); end
    total++; if (dqoe_cnt != 5) begin bad++; $display("FAIL wr_dqoe_cycles got=%0d want=5", dqoe_cnt); end
    total++; if (mem_do !== 8'h5A) begin bad++; $display("FAIL wr_do_kept got=%h want=5a", mem_do); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL wr_busy_end got=%b want=0", busy); end
  endtask

  task automatic test_back_to_back();
    int oe_cnt = 0;
    logic busy_gap = 1'b0, busy12 = 1'b1;
    logic [7:0] do5 = 8'h00, do10 = 8'h00, do11 = 8'h00;
    logic [AW-1:0] addr8 = '0;
    req_ce = 1'b1; req_oe = 1'b1; req_we = 1'b0; req_addr = 23'h000010;
    for (int e = 1; e <= 14; e++) begin
      @(negedge clk);
      if (!mem_oe_n) oe_cnt++;
      if (e <= 11 && busy !== 1'b1) busy_gap = 1'b1;
      if (e == 12) busy12 = busy;
      if (e == 5) do5 = mem_do;
      if (e == 10) do10 = mem_do;
      if (e == 11) do11 = mem_do;
      if (e == 8) addr8 = mem_addr;
      if (e == 3) req_addr = 23'h000011;
    end
    idle_inputs();
    total++; if (do5 !== data_of(23'h10)) begin bad++; $display("FAIL b2b_first_data got=%h want=%h", do5, data_of(23'h10)); end
    total++; if (do10 !== data_of(23'h10)) begin bad++; $display("FAIL b2b_first_held got=%h want=%h", do10, data_of(23'h10)); end
    total++; if (do11 !== data_of(23'h11)) begin bad++; $display("FAIL b2b_second_data got=%h want=%h", do11, data_of(23'h11)); end
    total++; if (addr8 !== 23'h000011) begin bad++; $display("FAIL b2b_second_addr got=%h want=000011", addr8); end
    total++; if (oe_cnt != 6) begin bad++; $display("FAIL b2b_oe_cycles got=%0d want=6", oe_cnt); end
    total++; if (busy_gap) begin bad++; $display("FAIL b2b_busy_gap got=gap want=continuous"); end
    total++; if (busy12 !== 1'b0) begin bad++; $display("FAIL b2b_busy_end got=%b want=0", busy12); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_wr_over_rd();
    int oe_cnt = 0, we_cnt = 0;
    logic busy11 = 1'b0, busy12 = 1'b1;
    logic [AW-1:0] addr8 = '0;
    req_ce = 1'b1; req_oe = 1'b1; req_we = 1'b0; req_addr = 23'h000020;
    for (int e = 1; e <= 16; e++) begin
      @(negedge clk);
      if (!mem_oe_n) oe_cnt++;
      if (!mem_we_n) we_cnt++;
      if (e == 8) addr8 = mem_addr;
      if (e == 11) busy11 = busy;
      if (e == 12) busy12 = busy;
      if (e == 2) begin req_oe = 1'b0; req_we = 1'b1; req_addr = 23'h000030; req_dati = 8'h77; end
      if (e == 3) begin req_oe = 1'b1; req_we = 1'b0; req_addr = 23'h000040; end
      if (e == 4) idle_inputs();
    end
    total++; if (oe_cnt != 3) begin bad++; $display("FAIL wor_oe_cycles got=%0d want=3", oe_cnt); end
    total++; if (we_cnt != 3) begin bad++; $display("FAIL wor_we_cycles got=%0d want=3", we_cnt); end
    total++; if (addr8 !== 23'h000030) begin bad++; $display("FAIL wor_wr_addr got=%h want=000030", addr8); end
    total++; if (mem_addr !== 23'h000030) begin bad++; $display("FAIL wor_final_addr got=%h want=000030", mem_addr); end
    total++; if (mem_dq_o !== 8'h77) begin bad++; $display("FAIL wor_wr_data got=%h want=77", mem_dq_o); end
    total++; if (mem_do !== data_of(23'h20)) begin bad++; $display("FAIL wor_do got=%h want=%h", mem_do, data_of(23'h20)); end
    total++; if (busy11 !== 1'b1) begin bad++; $display("FAIL wor_busy_hold got=%b want=1", busy11); end
    total++; if (busy12 !== 1'b0) begin bad++; $display("FAIL wor_busy_end got=%b want=0", busy12); end
  endtask

  task automatic test_reset_mid_write();
    req_ce = 1'b1; req_oe = 1'b0; req_we = 1'b1; req_addr = 23'h000050; req_dati = 8'h99;
    repeat (2) @(negedge clk);
    total++; if (mem_we_n !== 1'b0) begin bad++; $display("FAIL rmw_in_act got=%b want=0", mem_we_n); end
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    total++; if (mem_ce_n !== 1'b1) begin bad++; $display("FAIL rmw_ce_n got=%b want=1", mem_ce_n); end
    total++; if (mem_oe_n !== 1'b1) begin bad++; $display("FAIL rmw_oe_n got=%b want=1", mem_oe_n); end
    total++; if (mem_we_n !== 1'b1) begin bad++; $display("FAIL rmw_we_n got=%b want=1", mem_we_n); end
    total++; if (mem_dq_oe !== 1'b0) begin bad++; $display("FAIL rmw_dq_oe got=%b want=0", mem_dq_oe); end
    total++; if (mem_do !== 8'hFF) begin bad++; $display("FAIL rmw_do got=%h want=ff", mem_do); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmw_busy got=%b want=0", busy); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (mem_ce_n !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rmw_stays_idle got=ce_n:%b busy:%b want=1/0", mem_ce_n, busy); end
  endtask

  // Model: each accepted request becomes an access record starting one cycle after
  // acceptance; the expected pin values follow from the cycle offset into that record.
  task automatic test_random();
    bit            acc_vld = 0, acc_wr = 0;
    int            acc_start = 0, acc_end = 0;
    logic [AW-1:0] acc_addr = '0;
    bit            pend_vld = 0, pend_wr = 0;
    logic [AW-1:0] pend_addr = '0;
    logic [7:0]    pend_dat = 8'h00;
    bit            prev_rd = 0, prev_wr = 0;
    logic [AW-1:0] last_rd = '0, last_wr = '0;
    logic [AW-1:0] exp_addr = '0;
    logic [7:0]    exp_dqo = 8'h00, exp_do = 8'hFF;
    int            wr_expected = 0, wr_seen = 0;
    logic          prev_we_n = 1'b1;
    rst_n = 1'b0;
    idle_inputs();
    req_addr = '0; req_dati = 8'h00; dq_noise = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10000; k++) begin
      logic e_ce_n, e_oe_n, e_we_n, e_dq_oe, e_busy;
      bit   rd_now, wr_now, rd_det, wr_det, idle_now;
      int   ws, p;
      e_ce_n = 1'b1; e_oe_n = 1'b1; e_we_n = 1'b1; e_dq_oe = 1'b0;
      ws = acc_wr ? WR_WS : RD_WS;
      p  = k - acc_start;
      if (acc_vld && p >= 0 && p <= ws) begin
        e_ce_n  = 1'b0;
        e_dq_oe = acc_wr;
        if (p >= 1) begin e_oe_n = acc_wr; e_we_n = !acc_wr; end
      end else if (acc_vld && HOLD_CYC > 0 && p == ws + 1) begin
        e_dq_oe = acc_wr;
      end
      e_busy = (acc_vld && k < acc_end) || pend_vld;

      total++; if (mem_ce_n !== e_ce_n) begin bad++; $display("FAIL rnd_ce_n cyc=%0d got=%b want=%b", k, mem_ce_n, e_ce_n); end
      total++; if (mem_oe_n !== e_oe_n) begin bad++; $display("FAIL rnd_oe_n cyc=%0d got=%b want=%b", k, mem_oe_n, e_oe_n); end
      total++; if (mem_we_n !== e_we_n) begin bad++; $display("FAIL rnd_we_n cyc=%0d got=%b want=%b", k, mem_we_n, e_we_n); end
      total++; if (mem_dq_oe !== e_dq_oe) begin bad++; $display("FAIL rnd_dq_oe cyc=%0d got=%b want=%b", k, mem_dq_oe, e_dq_oe); end
      total++; if (mem_addr !== exp_addr) begin bad++; $display("FAIL rnd_addr cyc=%0d got=%h want=%h", k, mem_addr, exp_addr); end
      total++; if (mem_dq_o !== exp_dqo) begin bad++; $display("FAIL rnd_dq_o cyc=%0d got=%h want=%h", k, mem_dq_o, exp_dqo); end
      total++; if (mem_do !== exp_do) begin bad++; $display("FAIL rnd_do cyc=%0d got=%h want=%h", k, mem_do, exp_do); end
      total++; if (busy !== e_busy) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%b want=%b", k, busy, e_busy); end
      total++; if (!mem_oe_n && !mem_we_n) begin bad++; $display("FAIL rnd_oe_we_overlap cyc=%0d got=both_low want=not_both", k); end
      total++; if (mem_dq_oe && !mem_oe_n) begin bad++; $display("FAIL rnd_dq_contention cyc=%0d got=dq_oe_with_oe want=exclusive", k); end
      if (prev_we_n && !mem_we_n) wr_seen++;
      prev_we_n = mem_we_n;

      if ($urandom_range(0, 3) == 0) begin
        req_ce   = ($urandom_range(0, 9) != 0);
        req_oe   = 1'($urandom_range(0, 1));
        req_we   = ($urandom_range(0, 3) == 0);
        req_addr = addr_tab[$urandom_range(0, 3)];
        req_dati = 8'($urandom);
      end
      dq_noise = 8'($urandom);

      if (acc_vld && !acc_wr && k == acc_start + RD_WS) exp_do = data_of(acc_addr) ^ dq_noise;
      rd_now = req_ce && req_oe && !req_we;
      wr_now = req_ce && req_we;
      rd_det = rd_now && (!prev_rd || req_addr != last_rd);
      wr_det = wr_now && (!prev_wr || req_addr != last_wr);
      prev_rd = rd_now;
      prev_wr = wr_now;
      if (rd_det) last_rd = req_addr;
      if (wr_det) last_wr = req_addr;
      idle_now = !acc_vld || k >= acc_end;
      if (idle_now && (pend_vld || rd_det || wr_det)) begin
        acc_vld   = 1;
        acc_start = k + 1;
        if (pend_vld) begin
          acc_wr = pend_wr; acc_addr = pend_addr; exp_dqo = pend_dat;
          pend_vld = rd_det || wr_det;
          pend_wr = wr_det; pend_addr = req_addr; pend_dat = req_dati;
        end else begin
          acc_wr = wr_det; acc_addr = req_addr; exp_dqo = req_dati;
        end
        exp_addr = acc_addr;
        acc_end  = acc_start + (acc_wr ? WR_WS : RD_WS) + 1 + HOLD_CYC;
        if (acc_wr) wr_expected++;
      end else if (!idle_now && (rd_det || wr_det)) begin
        if (!(pend_vld && pend_wr && !wr_det)) begin
          pend_vld = 1; pend_wr = wr_det; pend_addr = req_addr; pend_dat = req_dati;
        end
      end
      @(negedge clk);
    end
    idle_inputs();
    total++; if (wr_seen != wr_expected) begin bad++; $display("FAIL rnd_write_count got=%0d want=%0d", wr_seen, wr_expected); end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    req_addr = '0;
    req_dati = 8'h00;
    dq_noise = 8'h00;
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_wr_over_rd();
    test_reset_mid_write();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
